// File: rtl/tlb_l2_miss_ctrl.sv
// L2 TLB front end: round-robin I/D arbitration, single L2 lookup, PTW walk + refill on miss; one translation in flight. Optional counters: TLB_L2_MISS_CTRL_STATS_EN.
// Latency: hit response at T+2, walked miss at T+N+4. Requesters see ready only in IDLE; the response is held until resp_ready_i.
module tlb_l2_miss_ctrl #(
   parameter int VA_W         = 64,
   parameter int PA_W         = 64,
   parameter int PERM_W       = 3,
   parameter int WALK_TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req_valid_i,
   output logic              i_req_ready_o,
   input  logic [VA_W-1:0]   i_req_vaddr_i,
   input  logic [PERM_W-1:0] i_req_perm_i,
   input  logic              d_req_valid_i,
   output logic              d_req_ready_o,
   input  logic [VA_W-1:0]   d_req_vaddr_i,
   input  logic [PERM_W-1:0] d_req_perm_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic              resp_id_o,
   output logic [PA_W-1:0]   resp_paddr_o,
   output logic              resp_fault_o,
   output logic              l2_req_valid_o,
   output logic [VA_W-1:0]   l2_req_vaddr_o,
   output logic [PERM_W-1:0] l2_req_perm_o,
   input  logic              l2_hit_i,
   input  logic [PA_W-1:0]   l2_paddr_i,
   input  logic              l2_fault_i,
   output logic              l2_refill_valid_o,
   output logic [VA_W-1:0]   l2_refill_vaddr_o,
   output logic [PA_W-1:0]   l2_refill_paddr_o,
   output logic [PERM_W-1:0] l2_refill_perm_o,
   output logic              ptw_req_valid_o,
   input  logic              ptw_req_ready_i,
   output logic [VA_W-1:0]   ptw_vaddr_o,
   input  logic              ptw_resp_valid_i,
   input  logic [PA_W-1:0]   ptw_paddr_i,
   input  logic [PERM_W-1:0] ptw_perm_i,
   input  logic              ptw_fault_i
`ifdef TLB_L2_MISS_CTRL_STATS_EN
   ,
   output logic [31:0]       stat_hits_o,
   output logic [31:0]       stat_misses_o,
   output logic [31:0]       stat_faults_o
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_WALK_REQ,
      S_WALK_WAIT,
      S_REFILL,
      S_RESP
   } state_t;

   typedef struct packed {
      logic [VA_W-1:0]   vaddr;
      logic [PERM_W-1:0] perm;
      logic              id;
   } req_t;

   localparam logic        TMO_EN   = (WALK_TIMEOUT != 0);
   localparam logic [31:0] TMO_LAST = (WALK_TIMEOUT != 0) ? 32'(WALK_TIMEOUT - 1) : 32'd0;

   state_t            state_q, state_d;
   req_t              req_q, req_d;
   logic [PA_W-1:0]   paddr_q, paddr_d;
   logic              fault_q, fault_d;
   logic [PERM_W-1:0] wperm_q, wperm_d;
   logic [31:0]       tmo_q, tmo_d;
   logic              rr_q, rr_d;
   logic              grant_i, grant_d;

   // rr_q=1 means the D side wins a tie; reset favours the I side.
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (i_req_valid_i && (!d_req_valid_i || !rr_q)) begin
         grant_i = 1'b1;
      end else if (d_req_valid_i) begin
         grant_d = 1'b1;
      end
   end

   assign i_req_ready_o = (state_q == S_IDLE) && grant_i;
   assign d_req_ready_o = (state_q == S_IDLE) && grant_d;

   always_comb begin
      state_d           = state_q;
      req_d             = req_q;
      paddr_d           = paddr_q;
      fault_d           = fault_q;
      wperm_d           = wperm_q;
      tmo_d             = tmo_q;
      rr_d              = rr_q;
      l2_req_valid_o    = 1'b0;
      ptw_req_valid_o   = 1'b0;
      l2_refill_valid_o = 1'b0;
      resp_valid_o      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (grant_i) begin
               req_d.vaddr = i_req_vaddr_i;
               req_d.perm  = i_req_perm_i;
               req_d.id    = 1'b0;
               rr_d        = 1'b1;
               state_d     = S_LOOKUP;
            end else if (grant_d) begin
               req_d.vaddr = d_req_vaddr_i;
               req_d.perm  = d_req_perm_i;
               req_d.id    = 1'b1;
               rr_d        = 1'b0;
               state_d     = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            l2_req_valid_o = 1'b1;
            if (l2_hit_i) begin
               paddr_d = l2_paddr_i;
               fault_d = l2_fault_i;
               state_d = S_RESP;
            end else begin
               state_d = S_WALK_REQ;
            end
         end
         S_WALK_REQ: begin
            ptw_req_valid_o = 1'b1;
            if (ptw_req_ready_i) begin
               tmo_d   = 32'd0;
               state_d = S_WALK_WAIT;
            end
         end
         S_WALK_WAIT: begin
            tmo_d = tmo_q + 32'd1;
            // A response in the final timeout cycle still wins over the timeout.
            if (ptw_resp_valid_i) begin
               if (ptw_fault_i) begin
                  fault_d = 1'b1;
                  paddr_d = '0;
                  state_d = S_RESP;
               end else begin
                  paddr_d = ptw_paddr_i;
                  wperm_d = ptw_perm_i;
                  fault_d = |(req_q.perm & ~ptw_perm_i);
                  state_d = S_REFILL;
               end
            end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
               fault_d = 1'b1;
               paddr_d = '0;
               state_d = S_RESP;
            end
         end
         S_REFILL: begin
            // Refill even on a permission fault: the mapping itself is valid.
            l2_refill_valid_o = 1'b1;
            state_d           = S_RESP;
         end
         S_RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         req_q   <= '0;
         paddr_q <= '0;
         fault_q <= 1'b0;
         wperm_q <= '0;
         tmo_q   <= 32'd0;
         rr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         paddr_q <= paddr_d;
         fault_q <= fault_d;
         wperm_q <= wperm_d;
         tmo_q   <= tmo_d;
         rr_q    <= rr_d;
      end
   end

   assign l2_req_vaddr_o    = req_q.vaddr;
   assign l2_req_perm_o     = req_q.perm;
   assign ptw_vaddr_o       = req_q.vaddr;
   assign l2_refill_vaddr_o = req_q.vaddr;
   assign l2_refill_paddr_o = paddr_q;
   assign l2_refill_perm_o  = wperm_q;
   assign resp_id_o         = req_q.id;
   assign resp_paddr_o      = paddr_q;
   assign resp_fault_o      = fault_q;

`ifdef TLB_L2_MISS_CTRL_STATS_EN
   logic [31:0] hits_q, hits_d;
   logic [31:0] misses_q, misses_d;
   logic [31:0] faults_q, faults_d;

   always_comb begin
      hits_d   = hits_q;
      misses_d = misses_q;
      faults_d = faults_q;
      if (state_q == S_LOOKUP) begin
         if (l2_hit_i) begin
            hits_d = hits_q + 32'd1;
         end else begin
            misses_d = misses_q + 32'd1;
         end
      end
      if ((state_d == S_RESP) && (state_q != S_RESP) && fault_d) begin
         faults_d = faults_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hits_q   <= 32'd0;
         misses_q <= 32'd0;
         faults_q <= 32'd0;
      end else begin
         hits_q   <= hits_d;
         misses_q <= misses_d;
         faults_q <= faults_d;
      end
   end

   assign stat_hits_o   = hits_q;
   assign stat_misses_o = misses_q;
   assign stat_faults_o = faults_q;
`endif

endmodule

// File: doc/tlb_l2_miss_ctrl.md
Name: tlb_l2_miss_ctrl

Overview:
- Front-end controller for the 512-entry 8-way L2 TLB.
- Round-robin arbitrates lookups between the I-side and D-side L1 TLB miss paths.
- Sequences the single L2 lookup.
- On an L2 miss, issues a page-table-walker (PTW) request, refills the L2 TLB with the result and returns the translation to the requester. One translation in flight at a time.

Parameters:
- VA_W, 64, virtual address width (matches the L2 TLB lookup port).
- PA_W, 64, physical address width.
- PERM_W, 3, permission bit-vector width.
- WALK_TIMEOUT, 1024, maximum cycles in WALK_WAIT before a timeout fault; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_req_valid_i  in  1  I-side translation request
- i_req_ready_o  out  1  I-side request accepted
- i_req_vaddr_i  in  VA_W  I-side virtual address
- i_req_perm_i  in  PERM_W  I-side required permissions
- d_req_valid_i  in  1  D-side translation request
- d_req_ready_o  out  1  D-side request accepted
- d_req_vaddr_i  in  VA_W  D-side virtual address
- d_req_perm_i  in  PERM_W  D-side required permissions
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed
- resp_id_o  out  1  response owner: 0 = I-side, 1 = D-side
- resp_paddr_o  out  PA_W  translated physical address
- resp_fault_o  out  1  permission, walk or timeout fault
- l2_req_valid_o  out  1  L2 TLB lookup strobe
- l2_req_vaddr_o  out  VA_W  L2 lookup address
- l2_req_perm_o  out  PERM_W  L2 lookup permissions
- l2_hit_i  in  1  L2 hit (combinational, same cycle)
- l2_paddr_i  in  PA_W  L2 hit physical address
- l2_fault_i  in  1  L2 permission fault
- l2_refill_valid_o  out  1  L2 refill strobe
- l2_refill_vaddr_o  out  VA_W  refill virtual address
- l2_refill_paddr_o  out  PA_W  refill physical address
- l2_refill_perm_o  out  PERM_W  refill permissions
- ptw_req_valid_o  out  1  walk request
- ptw_req_ready_i  in  1  walk request accepted
- ptw_vaddr_o  out  VA_W  walk virtual address
- ptw_resp_valid_i  in  1  walk result valid (single-cycle pulse)
- ptw_paddr_i  in  PA_W  walk physical address
- ptw_perm_i  in  PERM_W  walk permissions
- ptw_fault_i  in  1  walk fault (page not present)

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all *_valid_o, ready, resp_fault_o and resp_id_o are 0; address/perm outputs 0.
  - Round-robin pointer favours the I-side; timeout counter 0.
- FSM states: IDLE, LOOKUP, WALK_REQ, WALK_WAIT, REFILL, RESP.
- IDLE:
  - ready asserted combinationally only to the arbitration winner, and only in IDLE.
  - Only one side valid: that side wins.
  - Both valid: the side not granted last wins.
  - On handshake, latch vaddr, perm and id; toggle the pointer to the loser; go to LOOKUP.
- LOOKUP (exactly 1 cycle):
  - l2_req_valid_o=1 with the latched vaddr/perm.
  - l2_hit_i=1: latch paddr_i and fault_i, go to RESP.
  - Otherwise go to WALK_REQ.
- WALK_REQ:
  - ptw_req_valid_o=1 and ptw_vaddr_o stable until ptw_req_ready_i.
  - On handshake go to WALK_WAIT; clear the timeout counter.
- WALK_WAIT:
  - Counter increments each cycle.
  - On ptw_resp_valid_i:
    - ptw_fault_i=1: fault=1, paddr=0, go to RESP; no refill.
    - Otherwise: latch paddr/perm, fault=((perm_req & ~ptw_perm_i)!=0), go to REFILL.
  - WALK_TIMEOUT!=0 and counter reaches WALK_TIMEOUT-1 with no response: fault=1, paddr=0, go to RESP.
  - A PTW response arriving in any state other than WALK_WAIT is ignored.
- REFILL (exactly 1 cycle):
  - l2_refill_valid_o=1 with latched vaddr, paddr and perm; then RESP.
  - A refill is performed even when the permission check faults: the translation is valid, only the access is illegal.
- RESP:
  - resp_valid_o=1; id, paddr and fault stable until resp_ready_i.
  - On handshake go to IDLE. No new grant in the handshake cycle.
- Latency (request accepted in cycle T):
  - L2 hit: resp_valid_o at T+2.
  - Miss with PTW ready and response N cycles after the walk handshake: resp_valid_o at T+N+4.
- Requester inputs are sampled only at the accept handshake; later changes have no effect.
- Reset mid-walk: FSM returns to IDLE immediately; any subsequent ptw_resp_valid_i is ignored; no refill is issued.

Optional Feature:
- Macro TLB_L2_MISS_CTRL_STATS_EN.
- Defined: adds outputs stat_hits_o, stat_misses_o, stat_faults_o (32 bits each). Counters increment in LOOKUP on hit, in LOOKUP on miss, and on entry to RESP with fault=1, respectively. They wrap at 2^32, are cleared by reset, and have no effect on functional behaviour.
- Undefined: these ports and counters do not exist.

Test Plan:
- I-side only, vaddr=0x1000, perm=3'b001, L2 hit with paddr 0x8000 → resp_valid at T+2, id=0, paddr=0x8000, fault=0; no ptw_req_valid_o.
- I and D valid in the same cycle from reset → I granted first, D granted after the I response handshake; third simultaneous request → I wins again.
- D-side miss, vaddr=0x2000, PTW returns paddr 0x9000 perm=3'b011 three cycles after handshake → one-cycle refill strobe with {0x2000, 0x9000, 3'b011}, then response paddr=0x9000, fault=0.
- Miss with req perm=3'b100 and walk perm=3'b011 → refill issued, resp_fault_o=1; miss with ptw_fault_i=1 → no refill, fault=1, paddr=0.
- WALK_TIMEOUT=8, PTW never responds → fault response after exactly 8 WALK_WAIT cycles; a late ptw_resp_valid_i in IDLE is ignored.
- resp_ready_i held low 5 cycles → response outputs stable, both request readys 0; assert rst_n=0 during WALK_WAIT → all outputs 0 immediately and a following ptw response causes no refill.
